// File: rtl/gray_window_gen.sv
// gray_window_gen
//   Converts a streamed RGB pixel to 8-bit luma, keeps the two previous image
//   lines in on-chip line buffers and presents a registered 3x3 luma window,
//   with its centre coordinate, to the downstream Sobel/edge stage.
//
// Ports
//   clk        : single clock; all logic on the rising edge
//   rst        : synchronous active-high reset
//   en         : pixel-valid qualifier
//   in_R/G/B   : 8-bit colour components of the presented pixel
//   row, col   : coordinate of the presented pixel
//   win_out    : 3x3 window, row-major, p00 in [71:64] .. p22 in [7:0];
//                top row is the oldest line
//   win_valid  : one-cycle pulse per complete window
//   win_row    : centre row of the window
//   win_col    : centre column of the window
//   frame_done : pulses with the last valid window of a frame
//   coord_err  : sticky, set when an out-of-range coordinate is presented
//
// Pipeline: edge t registers luma (stage 1), edge t+1 reads the line
// buffers (registered read), edge t+2 shifts the window and updates outputs.

module gray_window_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COORD_W    = 13
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [7:0]         in_R,
   input  logic [7:0]         in_G,
   input  logic [7:0]         in_B,
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] col,
   output logic [71:0]        win_out,
   output logic               win_valid,
   output logic [COORD_W-1:0] win_row,
   output logic [COORD_W-1:0] win_col,
   output logic               frame_done,
   output logic               coord_err
);

   localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(IMG_WIDTH);
   localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(IMG_HEIGHT);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
   localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
   localparam logic [COORD_W-1:0] TWO_C    = COORD_W'(2);

   // ------------------------------------------------------------------
   // Stage 1: accept check and luma
   // ------------------------------------------------------------------
   logic               in_range;
   logic               accept;
   logic [15:0]        luma_sum;
   logic [7:0]         luma;

   logic               s1_valid_reg;
   logic [7:0]         s1_gray_reg;
   logic [COORD_W-1:0] s1_row_reg;
   logic [COORD_W-1:0] s1_col_reg;
   logic               coord_err_reg;

   always_comb begin
      in_range = (row < HEIGHT_C) && (col < WIDTH_C);
      accept   = en && in_range;
      // Weights sum to 256, so the top byte can never overflow.
      luma_sum = 16'd77 * {8'd0, in_R} + 16'd150 * {8'd0, in_G} + 16'd29 * {8'd0, in_B};
      luma     = 8'(luma_sum >> 8);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         coord_err_reg <= 1'b0;
      end else begin
         s1_valid_reg <= accept;
         if (en && !in_range) begin
            coord_err_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_gray_reg <= luma;
         s1_row_reg  <= row;
         s1_col_reg  <= col;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: line buffers. LA holds line r-1, LB holds line r-2.
   // The read of column c returns the pre-write contents; LA takes the new
   // luma at the same edge, LB takes the old LA value one edge later from
   // the registered tap, so each memory has one read and one write port.
   // ------------------------------------------------------------------
   logic [7:0]         la_mem [IMG_WIDTH];
   logic [7:0]         lb_mem [IMG_WIDTH];
   logic [ADDR_W-1:0]  s1_addr;
   logic [ADDR_W-1:0]  s2_addr;

   logic [7:0]         tapa_reg;
   logic [7:0]         tapb_reg;
   logic               s2_valid_reg;
   logic [7:0]         s2_gray_reg;
   logic [COORD_W-1:0] s2_row_reg;
   logic [COORD_W-1:0] s2_col_reg;

   assign s1_addr = s1_col_reg[ADDR_W-1:0];
   assign s2_addr = s2_col_reg[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (s1_valid_reg) begin
         tapa_reg <= la_mem[s1_addr];
         tapb_reg <= lb_mem[s1_addr];
         // A pixel caught by reset leaves no trace in the line buffers.
         if (!rst) begin
            la_mem[s1_addr] <= s1_gray_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s2_valid_reg) begin
         lb_mem[s2_addr] <= tapa_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_valid_reg) begin
         s2_gray_reg <= s1_gray_reg;
         s2_row_reg  <= s1_row_reg;
         s2_col_reg  <= s1_col_reg;
      end
   end

   // ------------------------------------------------------------------
   // Window: three 24-bit lines shifting left; the new right column is
   // {tapB, tapA, gray} from top to bottom. The working window shifts on
   // every stage-2 pixel, including border pixels, so it is kept separate
   // from the output register that only loads complete windows.
   // ------------------------------------------------------------------
   logic [23:0] new_col;
   logic [71:0] win_next;

   assign new_col = {tapb_reg, tapa_reg, s2_gray_reg};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_line
         logic [23:0] line_reg;

         assign win_next[71-24*gi -: 24] = {line_reg[15:0], new_col[23-8*gi -: 8]};

         always_ff @(posedge clk) begin
            if (s2_valid_reg) begin
               line_reg <= win_next[71-24*gi -: 24];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------
   logic               window_ok;
   logic [71:0]        win_out_reg;
   logic               win_valid_reg;
   logic [COORD_W-1:0] win_row_reg;
   logic [COORD_W-1:0] win_col_reg;
   logic               frame_done_reg;

   // Rows 0-1 and columns 0-1 would expose stale line-buffer data.
   assign window_ok = s2_valid_reg && (s2_row_reg >= TWO_C) && (s2_col_reg >= TWO_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         win_out_reg    <= '0;
         win_valid_reg  <= 1'b0;
         win_row_reg    <= '0;
         win_col_reg    <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         win_valid_reg  <= window_ok;
         frame_done_reg <= window_ok && (s2_row_reg == LAST_ROW) && (s2_col_reg == LAST_COL);
         if (window_ok) begin
            win_out_reg <= win_next;
            win_row_reg <= s2_row_reg - ONE_C;
            win_col_reg <= s2_col_reg - ONE_C;
         end
      end
   end

   assign win_out    = win_out_reg;
   assign win_valid  = win_valid_reg;
   assign win_row    = win_row_reg;
   assign win_col    = win_col_reg;
   assign frame_done = frame_done_reg;
   assign coord_err  = coord_err_reg;

endmodule

// File: tb/tb_gray_window_gen.sv
module tb_gray_window_gen;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [7:0]    in_R, in_G, in_B;
   logic [CW-1:0] row, col;
   logic [71:0]   win_out;
   logic          win_valid;
   logic [CW-1:0] win_row, win_col;
   logic          frame_done;
   logic          coord_err;

   always #5 clk = ~clk;

   gray_window_gen #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .COORD_W   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_R      (in_R),
      .in_G      (in_G),
      .in_B      (in_B),
      .row       (row),
      .col       (col),
      .win_out   (win_out),
      .win_valid (win_valid),
      .win_row   (win_row),
      .win_col   (win_col),
      .frame_done(frame_done),
      .coord_err (coord_err)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   bit chk_on  = 1'b0;
   int acc22   = 0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic int luma(input int r, input int g, input int b);
      return (77 * r + 150 * g + 29 * b) / 256;
   endfunction

   always @(posedge clk) cyc++;

   // ---------------- behavioural model ----------------
   // Each column remembers the lumas committed to it; a committed pixel
   // contributes the vertical triplet (two lines up, one line up, itself);
   // the window is the triplets of the last three committed pixels.
   int          col_hist [W][$];
   logic [23:0] trips[$];
   bit          m1_v = 0, m2_v = 0, m2_ok, m2_fd;
   int          m1_lum, m1_r, m1_c, m2_r, m2_c;
   logic [71:0] m2_win;
   logic [71:0] exp_win;
   logic        exp_valid, exp_fd, exp_err;
   logic [CW-1:0] exp_row, exp_col;
   int          top_v, mid_v, hs;
   bit          in_rng;

   always @(posedge clk) begin
      if (rst) begin
         exp_win = '0; exp_valid = 0; exp_fd = 0; exp_err = 0;
         exp_row = '0; exp_col = '0;
         m1_v = 0; m2_v = 0;
      end else begin
         exp_valid = m2_v && m2_ok;
         exp_fd    = exp_valid && m2_fd;
         if (exp_valid) begin
            exp_win = m2_win;
            exp_row = CW'(m2_r);
            exp_col = CW'(m2_c);
         end
         m2_v = m1_v;
         if (m1_v) begin
            hs    = col_hist[m1_c].size();
            top_v = (hs >= 2) ? col_hist[m1_c][hs-2] : 0;
            mid_v = (hs >= 1) ? col_hist[m1_c][hs-1] : 0;
            col_hist[m1_c].push_back(m1_lum);
            if (col_hist[m1_c].size() > 2) void'(col_hist[m1_c].pop_front());
            trips.push_back({8'(top_v), 8'(mid_v), 8'(m1_lum)});
            if (trips.size() > 3) void'(trips.pop_front());
            m2_win = '0;
            if (trips.size() == 3)
               for (int k = 0; k < 3; k++)
                  for (int j = 0; j < 3; j++)
                     m2_win[71-24*j-8*k -: 8] = trips[k][23-8*j -: 8];
            m2_ok = (m1_r >= 2) && (m1_c >= 2);
            m2_fd = (m1_r == H-1) && (m1_c == W-1);
            m2_r  = m1_r - 1;
            m2_c  = m1_c - 1;
         end
         in_rng = (int'(row) < H) && (int'(col) < W);
         m1_v   = en && in_rng;
         if (m1_v) begin
            m1_lum = luma(int'(in_R), int'(in_G), int'(in_B));
            m1_r   = int'(row);
            m1_c   = int'(col);
         end
         if (en && !in_rng) exp_err = 1;
      end
   end

   // ---------------- compare + capture ----------------
   typedef struct {
      logic [71:0]   win;
      logic [CW-1:0] r;
      logic [CW-1:0] c;
      logic          fd;
      int            cyc;
   } cap_t;
   cap_t caps[$];
   cap_t ref_seq[$];

   always @(negedge clk) begin
      if (chk_on) begin
         chk("win_out",    win_out,           exp_win);
         chk("win_valid",  72'(win_valid),    72'(exp_valid));
         chk("win_row",    72'(win_row),      72'(exp_row));
         chk("win_col",    72'(win_col),      72'(exp_col));
         chk("frame_done", 72'(frame_done),   72'(exp_fd));
         chk("coord_err",  72'(coord_err),    72'(exp_err));
         if (win_valid === 1'b1)
            caps.push_back('{win: win_out, r: win_row, c: win_col, fd: frame_done, cyc: cyc});
      end
   end

   // ---------------- stimulus ----------------
   int lr[6] = '{0, 255, 255, 0,   0,   0};
   int lg[6] = '{0, 255, 0,   255, 0,   0};
   int lb[6] = '{0, 255, 0,   0,   255, 0};

   task automatic set_pixel(input int r, input int c, input int mode);
      en  = 1'b1;
      row = CW'(r);
      col = CW'(c);
      case (mode)
         0: begin in_R = 8'(c); in_G = 8'(c); in_B = 8'(c); end
         1: begin in_R = 8'(r*10); in_G = 8'(r*10); in_B = 8'(r*10); end
         default: begin in_R = 8'(lr[r]); in_G = 8'(lg[r]); in_B = 8'(lb[r]); end
      endcase
   endtask

   task automatic drive_frame(input int mode, input bit bubble, input bit inject, input bit rst_mid);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (bubble && $urandom_range(0, 1) == 1) begin
               en = 1'b0;
               @(negedge clk);
            end
            set_pixel(r, c, mode);
            if (rst_mid && r == 3 && c == 4) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               en  = 1'b0;
               return;
            end
            if (r == 2 && c == 2) acc22 = cyc + 1;
            @(negedge clk);
            if (inject && r == 3 && c == 3) begin
               en = 1'b1; row = CW'(3); col = CW'(W);
               in_R = 8'd99; in_G = 8'd99; in_B = 8'd99;
               @(negedge clk);
               chk("coord_err_set", 72'(coord_err), 72'(1));
               row = CW'(H); col = CW'(3);
               @(negedge clk);
            end
         end
      end
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   int found, fd_cnt;
   logic [CW-1:0] fd_r, fd_c;
   int luma_exp[4] = '{255, 76, 149, 28};

   initial begin
      rst = 1'b1; en = 1'b0;
      in_R = '0; in_G = '0; in_B = '0; row = '0; col = '0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_win_out",   win_out,           72'(0));
      chk("rst_win_valid", 72'(win_valid),    72'(0));
      chk("rst_coord_err", 72'(coord_err),    72'(0));
      rst = 1'b0;
      @(negedge clk);

      // Luma: uniform colour lines, centre pixel of column-1 windows
      caps.delete();
      drive_frame(2, 0, 0, 0);
      found = 0;
      foreach (caps[i]) begin
         if (caps[i].c == CW'(1) && caps[i].r >= CW'(1) && caps[i].r <= CW'(4)) begin
            found++;
            chk($sformatf("luma_centre_r%0d", caps[i].r), 72'(caps[i].win[39:32]),
                72'(luma_exp[int'(caps[i].r) - 1]));
            if (caps[i].r == CW'(4))
               chk("luma_black_below", 72'(caps[i].win[15:8]), 72'(0));
         end
      end
      chk("luma_windows_found", 72'(found), 72'(4));

      // Ramp frame: latency, border, count, frame_done
      caps.delete();
      drive_frame(0, 0, 0, 0);
      chk("ramp_count", 72'(caps.size()), 72'(24));
      if (caps.size() > 0) begin
         chk("first_latency", 72'(caps[0].cyc - acc22), 72'(2));
         chk("first_row", 72'(caps[0].r), 72'(1));
         chk("first_col", 72'(caps[0].c), 72'(1));
         chk("first_win", caps[0].win, 72'h00_01_02_00_01_02_00_01_02);
      end
      fd_cnt = 0; fd_r = '0; fd_c = '0;
      foreach (caps[i]) if (caps[i].fd) begin fd_cnt++; fd_r = caps[i].r; fd_c = caps[i].c; end
      chk("frame_done_count", 72'(fd_cnt), 72'(1));
      chk("frame_done_at", 72'({fd_r, fd_c}), 72'({CW'(4), CW'(6)}));
      ref_seq = caps;

      // Vertical ordering
      caps.delete();
      drive_frame(1, 0, 0, 0);
      found = 0;
      foreach (caps[i]) if (caps[i].r == CW'(2) && caps[i].c == CW'(3)) begin
         found++;
         chk("vertical_win", caps[i].win, 72'h0A0A0A_141414_1E1E1E);
      end
      chk("vertical_found", 72'(found), 72'(1));

      // Bubbles: same window sequence as the uninterrupted ramp
      caps.delete();
      drive_frame(0, 1, 0, 0);
      chk("bubble_count", 72'(caps.size()), 72'(ref_seq.size()));
      foreach (caps[i]) if (i < ref_seq.size())
         chk($sformatf("bubble_seq_%0d", i), caps[i].win ^ 72'({caps[i].r, caps[i].c}),
             ref_seq[i].win ^ 72'({ref_seq[i].r, ref_seq[i].c}));

      // Out-of-range pixels injected mid-frame
      caps.delete();
      drive_frame(0, 0, 1, 0);
      chk("oor_count", 72'(caps.size()), 72'(ref_seq.size()));
      foreach (caps[i]) if (i < ref_seq.size())
         chk($sformatf("oor_seq_%0d", i), caps[i].win ^ 72'({caps[i].r, caps[i].c}),
             ref_seq[i].win ^ 72'({ref_seq[i].r, ref_seq[i].c}));
      chk("coord_err_sticky", 72'(coord_err), 72'(1));

      // Reset mid-frame at pixel (3,4)
      caps.delete();
      drive_frame(0, 0, 0, 1);
      chk("mid_rst_win_out",    win_out,          72'(0));
      chk("mid_rst_win_valid",  72'(win_valid),   72'(0));
      chk("mid_rst_row_col",    72'({win_row, win_col}), 72'(0));
      chk("mid_rst_frame_done", 72'(frame_done),  72'(0));
      chk("mid_rst_coord_err",  72'(coord_err),   72'(0));
      repeat (3) @(negedge clk);
      chk("mid_rst_no_pending", 72'(caps.size()), 72'(6));
      caps.delete();
      drive_frame(0, 0, 0, 0);
      chk("restart_count", 72'(caps.size()), 72'(24));
      if (caps.size() > 0) begin
         chk("restart_first_pos", 72'({caps[0].r, caps[0].c}), 72'({CW'(1), CW'(1)}));
         chk("restart_first_win", caps[0].win, 72'h00_01_02_00_01_02_00_01_02);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
